// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address helper for the write-back data cache.
package cache_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 3;
  localparam int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int NUM_SETS      = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    INSTALL
  } cache_state_e;

  // Byte address of one word of a line, as seen on the memory bus.
  function automatic logic [31:0] beat_addr(input logic [TAG_ADDR_LEN-1:0]  tag,
                                            input logic [SET_ADDR_LEN-1:0]  set_idx,
                                            input logic [LINE_ADDR_LEN-1:0] word);
    return {tag, set_idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Refill staging buffer: filled one beat at a time, installed as a whole line.
module cache_line_buf
  import cache_pkg::*;
(
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [LINE_ADDR_LEN-1:0]       wr_idx,
  input  logic [31:0]                    wr_data,
  output logic [LINE_WORDS-1:0][31:0]    line
);

  // Capture each acknowledged refill beat into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) line[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | serve hits combinationally; a miss picks WB or REFILL
// WB      | write the dirty victim line back, one word per mem_ack
// REFILL  | fetch the requested line into the line buffer, one word per ack
// INSTALL | copy the buffer into the set, new tag, valid and clean
module dcache_wb
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  cache_state_e state, state_nxt;

  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [LINE_ADDR_LEN-1:0] beat;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  req_tag;

  logic [TAG_ADDR_LEN-1:0]  tag_arr  [NUM_SETS];
  logic [31:0]              data_arr [NUM_SETS][LINE_WORDS];
  logic [NUM_SETS-1:0]      valid_arr;
  logic [NUM_SETS-1:0]      dirty_arr;
  logic [LINE_WORDS-1:0][31:0] fill_line;

  logic req, hit, idle_hit, victim_dirty, last_beat;
  logic post_fill, buf_we, start_miss;
  logic unused_addr_lsb;

  assign word_idx = addr[LINE_ADDR_LEN+1:2];
  assign set_idx  = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign req_tag  = addr[31:32-TAG_ADDR_LEN];
  assign unused_addr_lsb = ^addr[1:0];

  assign req          = rd_req | wr_req;
  assign hit          = req & valid_arr[set_idx] & (tag_arr[set_idx] == req_tag);
  assign idle_hit     = (state == IDLE) & hit;
  assign victim_dirty = valid_arr[set_idx] & dirty_arr[set_idx];
  assign last_beat    = (beat == '1);
  assign miss         = (state != IDLE) | (req & ~hit);
  assign rd_data      = rd_req ? data_arr[set_idx][word_idx] : '0;

  cache_line_buf u_line_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (beat),
    .wr_data (mem_rdata),
    .line    (fill_line)
  );

  // Next state and memory-bus outputs; the bus is idle outside WB and REFILL.
  always_comb begin
    state_nxt  = state;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    buf_we     = 1'b0;
    start_miss = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          start_miss = 1'b1;
          state_nxt  = victim_dirty ? WB : REFILL;
        end
      end
      WB: begin
        mem_wr_req = 1'b1;
        mem_addr   = beat_addr(tag_arr[set_idx], set_idx, beat);
        mem_wdata  = data_arr[set_idx][beat];
        if (mem_ack && last_beat) state_nxt = REFILL;
      end
      REFILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = beat_addr(req_tag, set_idx, beat);
        buf_we     = mem_ack;
        if (mem_ack && last_beat) state_nxt = INSTALL;
      end
      INSTALL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter, line status bits and access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      post_fill  <= 1'b0;
      valid_arr  <= '0;
      dirty_arr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_nxt;
      // The hit that completes a miss was already counted as a miss.
      post_fill <= (state == INSTALL);
      if ((state == WB || state == REFILL) && mem_ack) beat <= beat + 1'b1;
      if (start_miss) miss_count <= miss_count + 32'd1;
      if (idle_hit && !post_fill) hit_count <= hit_count + 32'd1;
      if (state == INSTALL) begin
        valid_arr[set_idx] <= 1'b1;
        dirty_arr[set_idx] <= 1'b0;
      end else if (idle_hit && wr_req) begin
        dirty_arr[set_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: line install after refill, byte-masked store on hit.
  always_ff @(posedge clk) begin
    if (!rst && state == INSTALL) begin
      tag_arr[set_idx] <= req_tag;
      for (int w = 0; w < LINE_WORDS; w++) data_arr[set_idx][w] <= fill_line[w];
    end else if (!rst && idle_hit && wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_arr[set_idx][word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios plus random accesses
// checked against a line-level cache/memory model.
module tb_dcache_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [3:0]  wr_be;
  logic [31:0] addr, wr_data, rd_data;
  logic        miss, mem_rd_req, mem_wr_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .wr_be      (wr_be),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .miss       (miss),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per-set line state plus a flat word memory.
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [23:0] m_tag   [8];
  logic [31:0] m_data  [8][8];
  logic [31:0] m_hits, m_misses;

  function automatic logic [31:0] mem_dflt(input logic [31:0] a);
    return 32'hA000_0000 | ({24'h0, a[15:8] ^ 8'h01} << 16)
                         | ({29'h0, a[7:5]} << 8) | {29'h0, a[4:2]};
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_dflt(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    m_hits   = '0;
    m_misses = '0;
  endtask

  // Memory responder: checks every requested beat against the model's list.
  int ack_period = 1;
  int wait_cnt   = 0;
  int beats_done = 0;
  bit stray_ack  = 1'b0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (rst) begin
        wait_cnt = 0;
        continue;
      end
      if (stray_ack) begin
        mem_ack   = 1'b1;
        stray_ack = 1'b0;
      end else if (mem_rd_req || mem_wr_req) begin
        check_eq("mem_req_exclusive", {31'b0, mem_rd_req & mem_wr_req}, 32'd0);
        check_eq("beat_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("beat_addr", mem_addr, exp_q[0].addr);
          check_eq("beat_is_wr", {31'b0, mem_wr_req}, {31'b0, exp_q[0].is_wr});
          if (wait_cnt >= ack_period - 1) begin
            wait_cnt = 0;
            mem_ack  = 1'b1;
            if (exp_q[0].is_wr) check_eq("wb_data", mem_wdata, exp_q[0].data);
            else                mem_rdata = exp_q[0].data;
            void'(exp_q.pop_front());
            beats_done++;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // One core access: predict with the model, hold the request until miss
  // drops, then check data, latency, counters and that all beats were seen.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d,
                           input bit chk_lat, output logic [31:0] got_rd);
    logic [2:0]  s, w;
    logic [23:0] t;
    logic [31:0] exp_rd, la;
    int          exp_cyc, ncyc;
    s = a[7:5];
    w = a[4:2];
    t = a[31:8];
    if (m_valid[s] && m_tag[s] == t) begin
      exp_cyc = 0;
      m_hits++;
    end else begin
      m_misses++;
      exp_cyc = 10;
      if (m_valid[s] && m_dirty[s]) begin
        exp_cyc = 18;
        for (int i = 0; i < 8; i++) begin
          la = {m_tag[s], s, 3'(i), 2'b00};
          exp_q.push_back('{1'b1, la, m_data[s][i]});
          mem[la] = m_data[s][i];
        end
      end
      for (int i = 0; i < 8; i++) begin
        la = {t, s, 3'(i), 2'b00};
        exp_q.push_back('{1'b0, la, mem_get(la)});
        m_data[s][i] = mem_get(la);
      end
      m_valid[s] = 1'b1;
      m_dirty[s] = 1'b0;
      m_tag[s]   = t;
    end
    exp_rd = m_data[s][w];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[s][w][8*b +: 8] = d[8*b +: 8];
      m_dirty[s] = 1'b1;
    end

    rd_req  = rd;
    wr_req  = wr;
    addr    = a;
    wr_be   = be;
    wr_data = d;
    #1;
    ncyc = 0;
    while (miss !== 1'b0 && ncyc < 400) begin
      ncyc++;
      @(negedge clk);
      #1;
    end
    check_eq("miss_released", {31'b0, miss}, 32'd0);
    if (chk_lat) check_eq("miss_cycles", 32'(ncyc), 32'(exp_cyc));
    got_rd = rd_data;
    if (rd) check_eq("rd_data", rd_data, exp_rd);
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    #1;
    check_eq("hit_count", hit_count, m_hits);
    check_eq("miss_count", miss_count, m_misses);
    check_eq("rd_data_no_read", rd_data, 32'd0);
    check_eq("beats_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  logic [7:0] tag_pool [4] = '{8'h01, 8'h05, 8'h09, 8'h31};

  initial begin
    logic [31:0] got;
    int          base, n;

    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    wr_be = '0; addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_miss", {31'b0, miss}, 32'd0);
    check_eq("rst_mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
    check_eq("rst_mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;

    // Cold miss, hit, byte-enable store, read-back, dirty eviction.
    do_access(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 1'b1, got);
    check_eq("cold_rd", got, 32'hA000_0001);
    do_access(1'b1, 1'b0, 32'h0000_0110, 4'h0, 32'h0, 1'b1, got);
    check_eq("hit_rd", got, 32'hA000_0004);
    do_access(1'b0, 1'b1, 32'h0000_0104, 4'b0101, 32'h1122_3344, 1'b1, got);
    do_access(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 1'b1, got);
    check_eq("be_store_rd", got, 32'hA022_0044);
    do_access(1'b1, 1'b0, 32'h0000_0504, 4'h0, 32'h0, 1'b1, got);

    // Reset after three refill acks of a clean miss.
    rd_req = 1'b1;
    addr   = 32'h0000_0904;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{1'b0, {24'h9, 3'd0, 3'(i), 2'b00}, mem_get({24'h9, 3'd0, 3'(i), 2'b00})});
    base = beats_done;
    n    = 0;
    while (beats_done < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre_reset_acks", 32'(beats_done - base), 32'd3);
    rst    = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    #1;
    check_eq("midrst_mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
    check_eq("midrst_mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
    check_eq("midrst_hit_count", hit_count, 32'd0);
    check_eq("midrst_miss_count", miss_count, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    do_access(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 1'b1, got);
    check_eq("post_rst_rd", got, 32'hA022_0044);

    // Stray ack while idle, then a refill from slow memory.
    stray_ack = 1'b1;
    @(negedge clk);
    #1;
    check_eq("stray_miss", {31'b0, miss}, 32'd0);
    check_eq("stray_mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
    check_eq("stray_hit_count", hit_count, m_hits);
    check_eq("stray_miss_count", miss_count, m_misses);
    ack_period = 3;
    do_access(1'b1, 1'b0, 32'h0000_0B2C, 4'h0, 32'h0, 1'b0, got);
    check_eq("slow_rd", got, 32'hA00A_0103);
    ack_period = 1;

    // Random mix over a few conflicting tags and sets.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          op;
      a  = {16'h0, tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 3)), 3'($urandom()), 2'b00};
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, a, 4'($urandom()), $urandom(), 1'b1, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache serving the core's MEM stage.
- Consumes the MEM-stage load/store request: word address taken from the ALU result, store data, 4-bit byte write enable.
- Produces the read word and the `miss` stall that the hazard unit uses to freeze the pipeline.
- Downstream, it talks to main memory over a word-serial request/ack handshake.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (8 words).
- SET_ADDR_LEN, 3, log2 of number of sets (8 sets).
- TAG_ADDR_LEN, 24, tag width; always equals 30 - LINE_ADDR_LEN - SET_ADDR_LEN.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  load request, held stable by core while miss=1.
- wr_req  in  1  store request, held stable while miss=1.
- wr_be  in  4  byte enables for store (bit i -> byte i).
- addr  in  32  byte address; bits [1:0] ignored.
- wr_data  in  32  store data.
- rd_data  out  32  load data, combinational, valid when rd_req=1 and miss=0.
- miss  out  1  stall to hazard unit.
- mem_rd_req  out  1  main-memory word read request.
- mem_wr_req  out  1  main-memory word write request.
- mem_addr  out  32  word-aligned byte address of current beat.
- mem_wdata  out  32  write-back beat data.
- mem_rdata  in  32  refill beat data, valid with mem_ack.
- mem_ack  in  1  one-cycle pulse completing the current beat.
- hit_count  out  32  accesses completed as hits.
- miss_count  out  32  accesses that started a miss.

Behaviour:
- Address split:
  - word offset = addr[LINE_ADDR_LEN+1:2].
  - set = next SET_ADDR_LEN bits.
  - tag = addr[31:32-TAG_ADDR_LEN].
- Per-set state: valid bit, dirty bit, tag, data line.
- hit = req & valid[set] & (tag_arr[set]==tag), where req = rd_req|wr_req.
- If both rd_req and wr_req are asserted, the access is treated as a write; rd_data is still driven.
- miss (combinational) = (state!=IDLE) | (req & ~hit).
- FSM states: IDLE, WB, REFILL, INSTALL.
  - IDLE, hit:
    - Read returns word from array in the same cycle; rd_data=0 when not reading.
    - Write updates enabled bytes at clk edge and sets dirty.
    - hit_count increments.
  - IDLE, miss, victim valid and dirty -> WB. miss_count increments on entry.
  - IDLE, miss, victim clean or invalid -> REFILL. miss_count increments on entry.
  - WB:
    - Beat counter 0..2^LINE-1.
    - mem_wr_req=1, mem_addr={victim tag, set, beat, 2'b00}, mem_wdata=victim word[beat].
    - On mem_ack the beat counter increments; the last ack -> REFILL, counter cleared.
  - REFILL:
    - mem_rd_req=1, mem_addr={req tag, set, beat, 2'b00}.
    - On mem_ack, mem_rdata is written into the line buffer slot [beat].
    - Last ack -> INSTALL.
  - INSTALL:
    - Writes buffer into the line, tag<=req tag, valid=1, dirty=0.
    - Next cycle -> IDLE; the still-held request now hits and is serviced as in IDLE (write sets dirty).
- mem_rd_req and mem_wr_req are never asserted together. Both are 0 in IDLE and INSTALL.
- mem_ack outside WB/REFILL is ignored.
- Miss latency, zero-wait memory acking every cycle: clean = 2^LINE + 2 cycles of miss; dirty = 2·2^LINE + 2.
- Counters wrap modulo 2^32. Each access is counted once (hit_count is not incremented for the post-refill hit).
- Reset values:
  - state=IDLE; all valid and dirty bits cleared; beat counter 0.
  - mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0.
  - hit_count=0, miss_count=0; rd_data=0 when no read.
  - Data and tag arrays are not cleared.
- Reset mid-WB/REFILL: the transfer is abandoned the same edge, request lines drop next cycle, and no partial line is installed.

Decomposition:
- Shared package `cache_pkg`:
  - state enum {IDLE, WB, REFILL, INSTALL}.
  - address-field width localparams derived from the parameters.
  - helper to assemble {tag,set,word,2'b00}.
- One sub-module: `cache_line_buf`, the refill buffer of 2^LINE words, written by beat index and read as a whole line.
- Tag, valid, dirty and data arrays stay in `dcache_wb`.

Test Plan:
- Cold-miss read:
  - Stimulus: rst then rd_req addr=0x0000_0104; memory acks every cycle returning 0xA000_0000+beat.
  - Required: miss high exactly 10 cycles; 8 read beats at 0x100..0x11C; then rd_data=0xA000_0001 with miss=0; miss_count=1.
- Hit after fill:
  - Stimulus: rd_req addr=0x0000_0110.
  - Required: miss=0 same cycle; rd_data=0xA000_0004; hit_count=1.
- Byte-enable store hit:
  - Stimulus: wr_req addr=0x104, wr_be=4'b0101, wr_data=0x1122_3344; then read 0x104.
  - Required: rd_data=0xA022_0044; line marked dirty.
- Dirty eviction:
  - Stimulus: rd_req addr=0x0000_0504, which maps to the same set as 0x104.
  - Required: 8 mem_wr beats at 0x100..0x11C with beat1 data 0xA022_0044; then 8 mem_rd beats at 0x500..; miss high 18 cycles; mem_rd_req and mem_wr_req never both 1.
- Reset during REFILL:
  - Stimulus: assert rst after 3 refill acks; release; rd_req 0x104.
  - Required: request lines 0 after reset; miss=1 (all lines invalid); fresh 8-beat refill from beat 0; counters restart at 0.
- Stray ack and slow memory:
  - Stimulus: mem_ack pulse while IDLE; then refill with mem_ack every 3rd cycle.
  - Required: stray ack has no effect; mem_addr holds each beat until its ack; final data is correct.
